// File: rtl/key_schedule_seq.sv
// AES-128 key expansion: presents round keys 0..10 one at a time over a
// valid/ready handshake, computing each next key from the current one.
module key_schedule_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FINISH
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_e         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     round_q, round_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_w3;
    logic [31:0]    t_word;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   next_key;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // g-function and word chain for the key following the one in key_q
    always_comb begin
        w0       = key_q[127:96];
        w1       = key_q[95:64];
        w2       = key_q[63:32];
        w3       = key_q[31:0];
        rot_w3   = {w3[23:0], w3[31:24]};
        t_word   = sub_word(rot_w3) ^ {rcon(round_q + 4'd1), 24'h000000};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = FINISH;
                    end else begin
                        key_d   = next_key;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign busy     = (state_q == EMIT);
    assign rk_valid = (state_q == EMIT);
    assign done     = (state_q == FINISH);
    assign rk_round = round_q;
    assign rk_out   = key_q;

endmodule
